// File: rtl/chacha_pkg.sv
// rtl/chacha_pkg.sv - shared types, rotation table and forward quarter round for the ChaCha inverse block
package chacha_pkg;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
  } qr_words_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } iqr_state_t;

  // Entries 0/1 rotate b (first/second use), entries 2/3 rotate d.
  localparam int IQR_ROT[4] = '{7, 12, 8, 16};

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic qr_words_t qr_fwd(input qr_words_t w);
    qr_words_t r;
    r   = w;
    r.a = r.a + r.b;
    r.d = rotl32(r.d ^ r.a, IQR_ROT[3]);
    r.c = r.c + r.d;
    r.b = rotl32(r.b ^ r.c, IQR_ROT[1]);
    r.a = r.a + r.b;
    r.d = rotl32(r.d ^ r.a, IQR_ROT[2]);
    r.c = r.c + r.d;
    r.b = rotl32(r.b ^ r.c, IQR_ROT[0]);
    return r;
  endfunction

endpackage

// File: rtl/chacha_inv_qr_step.sv
// rtl/chacha_inv_qr_step.sv - one combinational inverse quarter-round sub-step selected by k_i
module chacha_inv_qr_step
  import chacha_pkg::*;
(
  input  logic [1:0] k_i,
  input  qr_words_t  w_i,
  output qr_words_t  w_o
);

  // Even k undoes a (b,c) pair, odd k undoes a (d,a) pair; k[1] picks the earlier-applied rotation.
  always_comb begin
    w_o = w_i;
    if (!k_i[0]) begin
      w_o.b = (k_i[1] ? rotr32(w_i.b, IQR_ROT[1]) : rotr32(w_i.b, IQR_ROT[0])) ^ w_i.c;
      w_o.c = w_i.c - w_i.d;
    end else begin
      w_o.d = (k_i[1] ? rotr32(w_i.d, IQR_ROT[3]) : rotr32(w_i.d, IQR_ROT[2])) ^ w_i.a;
      w_o.a = w_i.a - w_i.b;
    end
  end

endmodule

// File: rtl/chacha_inv_quarter_round.sv
// rtl/chacha_inv_quarter_round.sv - iterative inverse ChaCha quarter round, one operation in flight
// Optional CHACHA_IQR_SELFCHECK_EN re-applies the forward round in DONE and flags mismatches on o_err.
module chacha_inv_quarter_round
  import chacha_pkg::*;
#(
  parameter int STEPS_PER_CYC = 1
) (
  input  logic        aclk,
  input  logic        arst,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_c,
  input  logic [31:0] i_d,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [31:0] o_a,
  output logic [31:0] o_b,
  output logic [31:0] o_c,
  output logic [31:0] o_d,
  output logic        o_err
);

  if (!(STEPS_PER_CYC == 1 || STEPS_PER_CYC == 2 || STEPS_PER_CYC == 4)) begin : g_bad_steps
    $error("chacha_inv_quarter_round: STEPS_PER_CYC must be 1, 2 or 4");
  end

  localparam logic [1:0] STEP_INC = STEPS_PER_CYC[1:0];

  iqr_state_t state_q;
  logic [1:0] step_q;
  logic [1:0] step_d;
  qr_words_t  words_q;
  logic       i_ready_q;
  logic       o_valid_q;
  logic       accept;
  qr_words_t  chain [STEPS_PER_CYC + 1];

  assign accept   = (state_q == IDLE) && i_valid;
  assign chain[0] = words_q;
  assign step_d   = step_q + STEP_INC;

  for (genvar j = 0; j < STEPS_PER_CYC; j++) begin : g_step
    logic [1:0] k;
    assign k = step_q + 2'(j);
    chacha_inv_qr_step u_step (
      .k_i (k),
      .w_i (chain[j]),
      .w_o (chain[j + 1])
    );
  end

  // step wraps to 0 exactly when all four sub-steps have been applied.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q   <= IDLE;
      step_q    <= 2'd0;
      words_q   <= '0;
      i_ready_q <= 1'b1;
      o_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            words_q   <= '{a: i_a, b: i_b, c: i_c, d: i_d};
            step_q    <= 2'd0;
            state_q   <= RUN;
            i_ready_q <= 1'b0;
          end
        end
        RUN: begin
          words_q <= chain[STEPS_PER_CYC];
          step_q  <= step_d;
          if (step_d == 2'd0) begin
            state_q   <= DONE;
            o_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (o_ready) begin
            state_q   <= IDLE;
            o_valid_q <= 1'b0;
            i_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          o_valid_q <= 1'b0;
          i_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign i_ready = i_ready_q;
  assign o_valid = o_valid_q;
  assign o_a     = words_q.a;
  assign o_b     = words_q.b;
  assign o_c     = words_q.c;
  assign o_d     = words_q.d;

`ifdef CHACHA_IQR_SELFCHECK_EN
  qr_words_t shadow_q;
  qr_words_t fwd_chk;

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      shadow_q <= '0;
    end else if (accept) begin
      shadow_q <= '{a: i_a, b: i_b, c: i_c, d: i_d};
    end
  end

  assign fwd_chk = qr_fwd(words_q);
  assign o_err   = (state_q == DONE) && (fwd_chk != shadow_q);
`else
  assign o_err = 1'b0;
`endif

endmodule
